if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Parametrised successor of the single-register fetch stage. Fetches sequential RV32I
//  instructions through a req/resp instruction-memory port (one request in flight).
//  Buffers {pc, instruction, irq} in a FIFO and presents them to ID with valid/ready.
//  Branch redirects flush the FIFO and discard any in-flight response.
// PARAMETERS
//  RESET_PC     32'h80000000  PC fetched first after reset
//  QUEUE_DEPTH  4             FIFO entries; power of two, >= 2
// PORTS
//  clk               in   1   clock
//  rst               in   1   synchronous active-high reset
//  irq               in   1   interrupt request; sampled into the entry at enqueue
//  br_en             in   1   redirect strobe from EX
//  br_pc             in   32  redirect target; bits [1:0] forced to 0 internally
//  instr_read        out  1   memory request; held until instr_mem_resp
//  instr_mem_address out  32  request address; stable while instr_read=1
//  instr_mem_resp    in   1   one-cycle response strobe; rdata valid with it
//  instr_mem_rdata   in   32  fetched instruction
//  if_id_valid       out  1   FIFO head valid
//  id_ready          in   1   ID accepts head this cycle
//  if_id             out  rv32i_pipereg::if_id_t  head entry {pc, instruction, irq}
// BEHAVIOUR
//  Reset values:
//  - state=IDLE; fetch_pc=RESET_PC; FIFO empty; instr_read=0; instr_mem_address=RESET_PC.
//  - if_id_valid=0; if_id=0.
//  States:
//  - IDLE: no request.
//  - WAIT: request out, data wanted.
//  - DROP: request out, data discarded.
//  instr_read=1 in WAIT and DROP only. instr_mem_address=req_pc register in every state.
//  space = (count_next < QUEUE_DEPTH). count_next includes this cycle's enqueue/dequeue.
//  IDLE:
//  - br_en: fetch_pc<=br_pc; ->WAIT at br_pc.
//  - else if space: req_pc<=fetch_pc; ->WAIT.
//  WAIT, br_en=0, resp=1: enqueue {req_pc, rdata, irq}; fetch_pc<=req_pc+4.
//  - ->WAIT at req_pc+4 if space, else ->IDLE.
//  WAIT, br_en=1, resp=0: flush FIFO; fetch_pc<=br_pc; ->DROP. Address stays at old req_pc.
//  WAIT, br_en=1, resp=1: discard rdata; flush FIFO; ->WAIT at br_pc.
//  DROP:
//  - resp=1: discard; ->WAIT at fetch_pc.
//  - br_en=1 (any resp): fetch_pc<=br_pc; resp=1 -> WAIT at br_pc, else stay DROP.
//  Dequeue when if_id_valid & id_ready.
//  - br_en the same cycle: head counts as accepted, then flush. br_en beats dequeue/enqueue.
//  if_id_valid=(count!=0). if_id comes combinationally from the head entry (0 when empty).
//  Latency:
//  - From rst deassert: instr_read=1 on the 2nd cycle.
//  - Enqueued entry visible at the head the cycle after resp. No bypass.
//  Full FIFO: no new request issued. The in-flight request always has a reserved slot.
//  PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFFFFFC+4 -> 0).
//  rst mid-request: returns to IDLE. A stray resp in IDLE is ignored.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_fetched[31:0], perf_discarded[31:0],
//   perf_stall[31:0].
//  - perf_fetched: enqueues.
//  - perf_discarded: dropped responses + flushed entries.
//  - perf_stall: cycles with if_id_valid=0.
//  - All reset to 0 and wrap.
//  IF_PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. rst 1->0, resp 2 cycles after each read, id_ready=1:
//     addresses 80000000, 80000004, 80000008 in order; if_id.pc matches.
//  2. id_ready=0, QUEUE_DEPTH=4, resp immediate:
//     4 entries enqueued, instr_read drops to 0; id_ready=1 resumes fetch at 80000010.
//  3. br_en=1, br_pc=80000103 while WAIT at 80000008, resp 3 cycles later:
//     response discarded, FIFO empty, next address 80000100.
//  4. br_en and resp in the same cycle (br_pc=80000200):
//     rdata not enqueued; next cycle instr_read=1, address 80000200.
//  5. br_en in the same cycle as a dequeue with 3 entries:
//     if_id_valid=0 next cycle; no stale entry ever presented.
//  6. IF_PERF_CNT_EN, scenario 3:
//     perf_discarded counts the dropped response plus flushed entries; perf_fetched
//     excludes the dropped response.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: sequential RV32I instruction fetch with a small output FIFO.
//
// Fetches consecutive words through a req/resp memory port, keeping one request in flight.
// Each response is buffered as {pc, instruction, irq} and handed to ID with valid/ready.
// A branch redirect flushes the FIFO and discards any response still outstanding.
//
// Parameters
//   RESET_PC     first PC fetched after reset
//   QUEUE_DEPTH  FIFO entries (power of two, >= 2)
// Ports
//   clk, rst            clock, synchronous active-high reset
//   irq                 interrupt request, captured into the entry at enqueue
//   br_en, br_pc        redirect strobe and target (bits [1:0] ignored)
//   instr_read          memory request, held until instr_mem_resp
//   instr_mem_address   request address, stable while instr_read is high
//   instr_mem_resp      one-cycle response strobe, instr_mem_rdata valid with it
//   if_id_valid/id_ready/if_id  head of the FIFO towards ID (if_id is 0 when empty)
// Optional build macro
//   IF_PERF_CNT_EN      adds perf_fetched, perf_discarded and perf_stall counters

package rv32i_pipereg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        irq;
    } if_id_t;
endpackage

module if_fetch_queue #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   irq,
    input  logic                   br_en,
    input  logic [31:0]            br_pc,
    output logic                   instr_read,
    output logic [31:0]            instr_mem_address,
    input  logic                   instr_mem_resp,
    input  logic [31:0]            instr_mem_rdata,
    output logic                   if_id_valid,
    input  logic                   id_ready,
    output rv32i_pipereg::if_id_t  if_id
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_discarded,
    output logic [31:0]            perf_stall
`endif
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    state_e                state_q, state_d;
    logic [31:0]           fetch_pc_q, fetch_pc_d;
    logic [31:0]           req_pc_q, req_pc_d;
    rv32i_pipereg::if_id_t mem_q [QUEUE_DEPTH];
    rv32i_pipereg::if_id_t mem_d [QUEUE_DEPTH];
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       count_q, count_d;

    logic        enq, deq, drop_resp, space;
    logic [31:0] br_tgt;
    logic [CntW-1:0] count_next;

    assign br_tgt = br_pc & 32'hFFFF_FFFC;
    assign deq    = if_id_valid & id_ready;
    // Responses are only kept in WAIT; a redirect in the same cycle kills them.
    assign enq    = (state_q == StWait) & instr_mem_resp & ~br_en;
    // Occupancy after this cycle; a redirect empties the FIFO (head still counts as taken).
    assign count_next = br_en ? '0 : (count_q + CntW'(enq) - CntW'(deq));
    // Issuing only when a slot is free guarantees the reply always has room.
    assign space = (count_next < CntW'(QUEUE_DEPTH));

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        drop_resp  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (br_en) begin
                    fetch_pc_d = br_tgt;
                    req_pc_d   = br_tgt;
                    state_d    = StWait;
                end else if (space) begin
                    req_pc_d = fetch_pc_q;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (br_en) begin
                    fetch_pc_d = br_tgt;
                    if (instr_mem_resp) begin
                        drop_resp = 1'b1;
                        req_pc_d  = br_tgt;
                    end else begin
                        // Old request is still outstanding; keep its address until it returns.
                        state_d = StDrop;
                    end
                end else if (instr_mem_resp) begin
                    fetch_pc_d = req_pc_q + 32'd4;
                    if (space) begin
                        req_pc_d = req_pc_q + 32'd4;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDrop: begin
                drop_resp = instr_mem_resp;
                if (br_en) begin
                    fetch_pc_d = br_tgt;
                    if (instr_mem_resp) begin
                        req_pc_d = br_tgt;
                        state_d  = StWait;
                    end
                end else if (instr_mem_resp) begin
                    req_pc_d = fetch_pc_q;
                    state_d  = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_next;
        if (br_en) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = '{pc: req_pc_q, instruction: instr_mem_rdata, irq: irq};
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign instr_read        = (state_q == StWait) || (state_q == StDrop);
    assign instr_mem_address = req_pc_q;
    assign if_id_valid       = (count_q != '0);
    assign if_id             = if_id_valid ? mem_q[rd_ptr_q] : '0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_discarded_q, perf_discarded_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d   = perf_fetched_q + 32'(enq);
        // Flushed entries exclude a head that ID accepts in the redirect cycle.
        perf_discarded_d = perf_discarded_q + 32'(drop_resp)
                         + (br_en ? (32'(count_q) - 32'(deq)) : 32'd0);
        perf_stall_d     = perf_stall_q + 32'(~if_id_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q   <= '0;
            perf_discarded_q <= '0;
            perf_stall_q     <= '0;
        end else begin
            perf_fetched_q   <= perf_fetched_d;
            perf_discarded_q <= perf_discarded_d;
            perf_stall_q     <= perf_stall_d;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_discarded = perf_discarded_q;
    assign perf_stall     = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: a directed cycle table, a randomized run against a stream-level
// model (expected PC sequence, memory contents, irq captured at response), and a few
// hand-written corner sequences (reset mid-request, stray response, PC wrap).

module tb_if_fetch_queue;
    import rv32i_pipereg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        irq = 1'b0;
    logic        br_en = 1'b0;
    logic [31:0] br_pc = '0;
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic        instr_mem_resp = 1'b0;
    logic [31:0] instr_mem_rdata = '0;
    logic        if_id_valid;
    logic        id_ready = 1'b0;
    if_id_t      if_id;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_discarded, perf_stall;
`endif

    if_fetch_queue #(
        .RESET_PC    (32'h8000_0000),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .irq               (irq),
        .br_en             (br_en),
        .br_pc             (br_pc),
        .instr_read        (instr_read),
        .instr_mem_address (instr_mem_address),
        .instr_mem_resp    (instr_mem_resp),
        .instr_mem_rdata   (instr_mem_rdata),
        .if_id_valid       (if_id_valid),
        .id_ready          (id_ready),
        .if_id             (if_id)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_discarded    (perf_discarded),
        .perf_stall        (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
    endfunction

    typedef struct {
        logic        br;
        logic [31:0] bpc;
        logic        rs;
        logic [31:0] rd;
        logic        iq;
        logic        rdy;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [64:0] e_ifid;
    } vec_t;

    function automatic vec_t mk(logic br, logic [31:0] bpc, logic rs, logic [31:0] rd, logic iq,
                                logic rdy, logic er, logic [31:0] ea, logic ev,
                                logic [31:0] epc, logic [31:0] ein, logic eiq);
        vec_t v;
        v.br = br; v.bpc = bpc; v.rs = rs; v.rd = rd; v.iq = iq; v.rdy = rdy;
        v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.e_ifid = {epc, ein, eiq};
        return v;
    endfunction

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic drive_idle();
        br_en = 1'b0; br_pc = '0; instr_mem_resp = 1'b0; instr_mem_rdata = '0;
        irq = 1'b0; id_ready = 1'b0;
    endtask

    // Random-phase state
    bit          irq_map [logic [31:0]];
    logic [31:0] exp_pc;
    bit          pending;
    int unsigned delay;
    logic        prev_read, prev_resp;
    logic [31:0] prev_addr;
    int          accepted;

    initial begin
        // Outputs observed this cycle, inputs applied for the following edge.
        //             br  br_pc          rs rdata          iq rdy | rd addr        v  pc  instr  irq
        vecs[0]  = mk(0, 0,             0, 0,             0, 1,   0, 32'h80000000, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0,             0, 0,             0, 1,   1, 32'h80000000, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0,             0, 0,             0, 1,   1, 32'h80000000, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0,             1, 32'h1111_0000, 0, 1,   1, 32'h80000000, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0,             0, 0,             0, 1,   1, 32'h80000004, 1,
                      32'h80000000, 32'h1111_0000, 0);
        vecs[5]  = mk(0, 0,             0, 0,             0, 1,   1, 32'h80000004, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0,             1, 32'h1111_0001, 0, 1,   1, 32'h80000004, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0,             0, 0,             0, 1,   1, 32'h80000008, 1,
                      32'h80000004, 32'h1111_0001, 0);
        vecs[8]  = mk(1, 32'h80000200,  1, 32'h1111_0002, 0, 1,   1, 32'h80000008, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0,             0, 0,             0, 1,   1, 32'h80000200, 0, 0, 0, 0);
        vecs[10] = mk(1, 32'h80000103,  0, 0,             0, 1,   1, 32'h80000200, 0, 0, 0, 0);
        vecs[11] = mk(0, 0,             0, 0,             0, 1,   1, 32'h80000200, 0, 0, 0, 0);
        vecs[12] = mk(0, 0,             0, 0,             0, 1,   1, 32'h80000200, 0, 0, 0, 0);
        vecs[13] = mk(0, 0,             1, 32'hDEAD_BEEF, 0, 1,   1, 32'h80000200, 0, 0, 0, 0);
        vecs[14] = mk(0, 0,             1, 32'h1111_0003, 1, 1,   1, 32'h80000100, 0, 0, 0, 0);
        vecs[15] = mk(0, 0,             1, 32'h1111_0004, 0, 0,   1, 32'h80000104, 1,
                      32'h80000100, 32'h1111_0003, 1);
        vecs[16] = mk(0, 0,             1, 32'h1111_0005, 0, 0,   1, 32'h80000108, 1,
                      32'h80000100, 32'h1111_0003, 1);
        vecs[17] = mk(0, 0,             1, 32'h1111_0006, 0, 0,   1, 32'h8000010C, 1,
                      32'h80000100, 32'h1111_0003, 1);
        vecs[18] = mk(0, 0,             0, 0,             0, 0,   0, 32'h8000010C, 1,
                      32'h80000100, 32'h1111_0003, 1);
        vecs[19] = mk(0, 0,             0, 0,             0, 1,   0, 32'h8000010C, 1,
                      32'h80000100, 32'h1111_0003, 1);
        vecs[20] = mk(1, 32'h80000300,  0, 0,             0, 1,   1, 32'h80000110, 1,
                      32'h80000104, 32'h1111_0004, 0);
        vecs[21] = mk(0, 0,             1, 32'hBAD0_0000, 0, 1,   1, 32'h80000110, 0, 0, 0, 0);
        vecs[22] = mk(0, 0,             0, 0,             0, 1,   1, 32'h80000300, 0, 0, 0, 0);

        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("t%0d_read", i), instr_read, vecs[i].e_read);
            chk($sformatf("t%0d_addr", i), instr_mem_address, vecs[i].e_addr);
            chk($sformatf("t%0d_valid", i), if_id_valid, vecs[i].e_valid);
            chk($sformatf("t%0d_ifid", i), if_id, vecs[i].e_ifid);
            rst             = 1'b0;
            br_en           = vecs[i].br;
            br_pc           = vecs[i].bpc;
            instr_mem_resp  = vecs[i].rs;
            instr_mem_rdata = vecs[i].rd;
            irq             = vecs[i].iq;
            id_ready        = vecs[i].rdy;
        end
        @(negedge clk);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'd6);
        chk("perf_discarded", perf_discarded, 32'd5);
        chk("perf_stall", perf_stall, 32'd15);
`endif

        // Randomized run against the stream model.
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        exp_pc    = 32'h8000_0000;
        pending   = 1'b0;
        delay     = 0;
        prev_read = 1'b0;
        prev_resp = 1'b0;
        prev_addr = '0;
        accepted  = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!if_id_valid) chk("empty_ifid_zero", if_id, 65'd0);
            if (prev_read && !prev_resp) begin
                chk("hold_read", instr_read, 1'b1);
                chk("hold_addr", instr_mem_address, prev_addr);
            end
            id_ready = ($urandom_range(0, 3) != 0);
            irq      = $urandom_range(0, 1) == 1;
            br_en    = ($urandom_range(0, 19) == 0);
            br_pc    = 32'h8000_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            if (instr_read && !pending) begin
                pending = 1'b1;
                delay   = $urandom_range(0, 3);
            end
            instr_mem_resp  = 1'b0;
            instr_mem_rdata = '0;
            if (pending) begin
                if (delay == 0) begin
                    instr_mem_resp  = 1'b1;
                    instr_mem_rdata = mem_word(instr_mem_address);
                    pending         = 1'b0;
                end else begin
                    delay--;
                end
            end
            if (if_id_valid && id_ready) begin
                chk("acc_pc", if_id.pc, exp_pc);
                chk("acc_instr", if_id.instruction, mem_word(exp_pc));
                chk("acc_irq", if_id.irq, irq_map.exists(exp_pc) ? irq_map[exp_pc] : 1'bx);
                exp_pc = exp_pc + 32'd4;
                accepted++;
            end
            if (br_en) exp_pc = br_pc & 32'hFFFF_FFFC;
            if (instr_mem_resp) irq_map[instr_mem_address] = irq;
            prev_read = instr_read;
            prev_resp = instr_mem_resp;
            prev_addr = instr_mem_address;
        end
        chk("progress", accepted >= 100, 1'b1);

        // Reset while a request may be outstanding.
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_read", instr_read, 1'b0);
        chk("rst_addr", instr_mem_address, 32'h8000_0000);
        chk("rst_valid", if_id_valid, 1'b0);
        chk("rst_ifid", if_id, 65'd0);

        // Redirect out of IDLE with a stray response, then PC wrap.
        rst             = 1'b0;
        br_en           = 1'b1;
        br_pc           = 32'hFFFF_FFFF;
        instr_mem_resp  = 1'b1;
        instr_mem_rdata = 32'h0000_0777;
        @(negedge clk);
        chk("wrap_read", instr_read, 1'b1);
        chk("wrap_addr", instr_mem_address, 32'hFFFF_FFFC);
        chk("stray_valid", if_id_valid, 1'b0);
        br_en           = 1'b0;
        instr_mem_resp  = 1'b1;
        instr_mem_rdata = 32'h0000_0007;
        irq             = 1'b1;
        @(negedge clk);
        drive_idle();
        chk("wrap_next_addr", instr_mem_address, 32'h0000_0000);
        chk("wrap_valid", if_id_valid, 1'b1);
        chk("wrap_ifid", if_id, {32'hFFFF_FFFC, 32'h0000_0007, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
